// File: rtl/l1_store_l2_port.sv
// l1_store_l2_port: forwards store / store_sync / flush requests from the L1
// store queue to the L2 request channel through a single registered packet
// slot, tracks outstanding entries per thread, and returns store-class
// completions from the L2 response channel to the store queue.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   sq_dequeue_*                store queue dequeue request; ack is combinational
//   l2_request_*                outbound packet (valid/ready handshake)
//   l2_response_*               inbound response beats (type 3 ignored)
//   storebuf_l2_response_*      1-cycle completion pulse with idx/status
//   storebuf_l2_sync_success    sync status for store_sync completions
//   port_error                  sticky protocol error, cleared only by reset
module l1_store_l2_port #(
    parameter int unsigned THREADS    = 4,
    parameter int unsigned LINE_BYTES = 64,
    parameter int unsigned ADDR_WIDTH = 32,
    localparam int unsigned ID_W      = (THREADS > 1) ? $clog2(THREADS) : 1,
    localparam int unsigned DATA_W    = 8 * LINE_BYTES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sq_dequeue_ready,
    input  logic [ADDR_WIDTH-1:0] sq_dequeue_addr,
    input  logic [ID_W-1:0]       sq_dequeue_idx,
    input  logic [LINE_BYTES-1:0] sq_dequeue_mask,
    input  logic [DATA_W-1:0]     sq_dequeue_data,
    input  logic                  sq_dequeue_synchronized,
    input  logic                  sq_dequeue_flush,
    output logic                  sq_dequeue_ack,
    output logic                  l2_request_valid,
    input  logic                  l2_request_ready,
    output logic [1:0]            l2_request_type,
    output logic [ID_W-1:0]       l2_request_id,
    output logic [ADDR_WIDTH-1:0] l2_request_addr,
    output logic [LINE_BYTES-1:0] l2_request_mask,
    output logic [DATA_W-1:0]     l2_request_data,
    input  logic                  l2_response_valid,
    input  logic [1:0]            l2_response_type,
    input  logic [ID_W-1:0]       l2_response_id,
    input  logic                  l2_response_status,
    output logic                  storebuf_l2_response_valid,
    output logic [ID_W-1:0]       storebuf_l2_response_idx,
    output logic                  storebuf_l2_sync_success,
    output logic                  port_error
);

    localparam logic [1:0] TYPE_STORE = 2'd0;
    localparam logic [1:0] TYPE_SYNC  = 2'd1;
    localparam logic [1:0] TYPE_FLUSH = 2'd2;
    localparam logic [1:0] TYPE_OTHER = 2'd3;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [THREADS-1:0] outstanding;
    logic [THREADS-1:0] outstanding_next;
    logic [1:0]         sent_type [THREADS];
    logic [1:0]         req_type;
    logic               rsp_class;
    logic               rsp_known;
    logic               rsp_mismatch;

    // Packet slot state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Accept decision and slot next-state; ack uses pre-edge outstanding bits
    always_comb begin
        state_next     = state;
        sq_dequeue_ack = 1'b0;
        if (sq_dequeue_ready && !outstanding[sq_dequeue_idx] &&
            ((state == EMPTY) || l2_request_ready)) begin
            sq_dequeue_ack = 1'b1;
        end
        case (state)
            EMPTY: if (sq_dequeue_ack) state_next = FULL;
            FULL:  if (l2_request_ready && !sq_dequeue_ack) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    assign l2_request_valid = (state == FULL);

    // Request type: flush wins over synchronized
    always_comb begin
        req_type = TYPE_STORE;
        if (sq_dequeue_flush) begin
            req_type = TYPE_FLUSH;
        end else if (sq_dequeue_synchronized) begin
            req_type = TYPE_SYNC;
        end
    end

    // Response classification
    always_comb begin
        rsp_class    = l2_response_valid && (l2_response_type != TYPE_OTHER);
        rsp_known    = outstanding[l2_response_id];
        rsp_mismatch = (sent_type[l2_response_id] != l2_response_type);
    end

    // Outstanding update: response clear and accept set never share an id
    always_comb begin
        outstanding_next = outstanding;
        if (rsp_class && rsp_known) begin
            outstanding_next[l2_response_id] = 1'b0;
        end
        if (sq_dequeue_ack) begin
            outstanding_next[sq_dequeue_idx] = 1'b1;
        end
    end

    // Packet register, tracking state and completion outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            l2_request_type            <= TYPE_STORE;
            l2_request_id              <= '0;
            l2_request_addr            <= '0;
            l2_request_mask            <= '0;
            l2_request_data            <= '0;
            outstanding                <= '0;
            for (int i = 0; i < int'(THREADS); i++) begin
                sent_type[i] <= TYPE_STORE;
            end
            storebuf_l2_response_valid <= 1'b0;
            storebuf_l2_response_idx   <= '0;
            storebuf_l2_sync_success   <= 1'b0;
            port_error                 <= 1'b0;
        end else begin
            if (sq_dequeue_ack) begin
                l2_request_type           <= req_type;
                l2_request_id             <= sq_dequeue_idx;
                l2_request_addr           <= sq_dequeue_addr;
                l2_request_mask           <= sq_dequeue_mask;
                l2_request_data           <= sq_dequeue_data;
                sent_type[sq_dequeue_idx] <= req_type;
            end
            outstanding <= outstanding_next;

            storebuf_l2_response_valid <= rsp_class && rsp_known;
            storebuf_l2_sync_success   <= rsp_class && rsp_known &&
                                          (l2_response_type == TYPE_SYNC) &&
                                          l2_response_status;
            if (rsp_class && rsp_known) begin
                storebuf_l2_response_idx <= l2_response_id;
            end

            // Unknown id or type mismatch both flag; mismatches still complete
            if (rsp_class && (!rsp_known || rsp_mismatch)) begin
                port_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_l1_store_l2_port.sv
// Directed testbench for l1_store_l2_port.
module tb_l1_store_l2_port;

    localparam int unsigned THREADS    = 4;
    localparam int unsigned LINE_BYTES = 64;
    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned ID_W       = 2;
    localparam int unsigned DATA_W     = 512;

    logic                  clk;
    logic                  reset;
    logic                  sq_dequeue_ready;
    logic [ADDR_WIDTH-1:0] sq_dequeue_addr;
    logic [ID_W-1:0]       sq_dequeue_idx;
    logic [LINE_BYTES-1:0] sq_dequeue_mask;
    logic [DATA_W-1:0]     sq_dequeue_data;
    logic                  sq_dequeue_synchronized;
    logic                  sq_dequeue_flush;
    logic                  sq_dequeue_ack;
    logic                  l2_request_valid;
    logic                  l2_request_ready;
    logic [1:0]            l2_request_type;
    logic [ID_W-1:0]       l2_request_id;
    logic [ADDR_WIDTH-1:0] l2_request_addr;
    logic [LINE_BYTES-1:0] l2_request_mask;
    logic [DATA_W-1:0]     l2_request_data;
    logic                  l2_response_valid;
    logic [1:0]            l2_response_type;
    logic [ID_W-1:0]       l2_response_id;
    logic                  l2_response_status;
    logic                  storebuf_l2_response_valid;
    logic [ID_W-1:0]       storebuf_l2_response_idx;
    logic                  storebuf_l2_sync_success;
    logic                  port_error;

    int passed = 0;
    int total  = 0;

    l1_store_l2_port #(
        .THREADS    (THREADS),
        .LINE_BYTES (LINE_BYTES),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk                        (clk),
        .reset                      (reset),
        .sq_dequeue_ready           (sq_dequeue_ready),
        .sq_dequeue_addr            (sq_dequeue_addr),
        .sq_dequeue_idx             (sq_dequeue_idx),
        .sq_dequeue_mask            (sq_dequeue_mask),
        .sq_dequeue_data            (sq_dequeue_data),
        .sq_dequeue_synchronized    (sq_dequeue_synchronized),
        .sq_dequeue_flush           (sq_dequeue_flush),
        .sq_dequeue_ack             (sq_dequeue_ack),
        .l2_request_valid           (l2_request_valid),
        .l2_request_ready           (l2_request_ready),
        .l2_request_type            (l2_request_type),
        .l2_request_id              (l2_request_id),
        .l2_request_addr            (l2_request_addr),
        .l2_request_mask            (l2_request_mask),
        .l2_request_data            (l2_request_data),
        .l2_response_valid          (l2_response_valid),
        .l2_response_type           (l2_response_type),
        .l2_response_id             (l2_response_id),
        .l2_response_status         (l2_response_status),
        .storebuf_l2_response_valid (storebuf_l2_response_valid),
        .storebuf_l2_response_idx   (storebuf_l2_response_idx),
        .storebuf_l2_sync_success   (storebuf_l2_sync_success),
        .port_error                 (port_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sq_req(input logic [ID_W-1:0] idx, input logic [ADDR_WIDTH-1:0] addr,
                          input logic [LINE_BYTES-1:0] mask, input logic [DATA_W-1:0] data,
                          input logic sync, input logic flush);
        sq_dequeue_ready        = 1'b1;
        sq_dequeue_idx          = idx;
        sq_dequeue_addr         = addr;
        sq_dequeue_mask         = mask;
        sq_dequeue_data         = data;
        sq_dequeue_synchronized = sync;
        sq_dequeue_flush        = flush;
    endtask

    task automatic sq_idle();
        sq_dequeue_ready        = 1'b0;
        sq_dequeue_synchronized = 1'b0;
        sq_dequeue_flush        = 1'b0;
    endtask

    task automatic rsp(input logic [1:0] typ, input logic [ID_W-1:0] id, input logic st);
        l2_response_valid  = 1'b1;
        l2_response_type   = typ;
        l2_response_id     = id;
        l2_response_status = st;
    endtask

    logic [DATA_W-1:0] pat_a;
    logic [DATA_W-1:0] pat_b;

    initial begin
        pat_a = {16{32'hDEADBEEF}};
        pat_b = {16{32'h01234567}};
        reset = 1'b0;
        sq_dequeue_ready = 1'b0;
        sq_dequeue_addr = '0;
        sq_dequeue_idx = '0;
        sq_dequeue_mask = '0;
        sq_dequeue_data = '0;
        sq_dequeue_synchronized = 1'b0;
        sq_dequeue_flush = 1'b0;
        l2_request_ready = 1'b0;
        l2_response_valid = 1'b0;
        l2_response_type = 2'd0;
        l2_response_id = '0;
        l2_response_status = 1'b0;

        // Reset values
        #2;
        chk("rst_valid", DATA_W'(l2_request_valid), 0);
        chk("rst_type", DATA_W'(l2_request_type), 0);
        chk("rst_id", DATA_W'(l2_request_id), 0);
        chk("rst_addr", DATA_W'(l2_request_addr), 0);
        chk("rst_mask", DATA_W'(l2_request_mask), 0);
        chk("rst_data", l2_request_data, 0);
        chk("rst_sb_valid", DATA_W'(storebuf_l2_response_valid), 0);
        chk("rst_sb_idx", DATA_W'(storebuf_l2_response_idx), 0);
        chk("rst_sb_sync", DATA_W'(storebuf_l2_sync_success), 0);
        chk("rst_err", DATA_W'(port_error), 0);
        tick();
        tick();
        reset = 1'b1;

        // Single store, ready held high
        l2_request_ready = 1'b1;
        sq_req(2'd2, 32'h1000, 64'hF, pat_a, 1'b0, 1'b0);
        #1 chk("s1_ack", DATA_W'(sq_dequeue_ack), 1);
        tick();
        sq_idle();
        chk("s1_valid", DATA_W'(l2_request_valid), 1);
        chk("s1_type", DATA_W'(l2_request_type), 0);
        chk("s1_id", DATA_W'(l2_request_id), 2);
        chk("s1_addr", DATA_W'(l2_request_addr), 32'h1000);
        chk("s1_mask", DATA_W'(l2_request_mask), 64'hF);
        chk("s1_data", l2_request_data, pat_a);
        tick();
        chk("s1_gone", DATA_W'(l2_request_valid), 0);
        rsp(2'd0, 2'd2, 1'b0);
        tick();
        l2_response_valid = 1'b0;
        chk("s1_pulse", DATA_W'(storebuf_l2_response_valid), 1);
        chk("s1_pidx", DATA_W'(storebuf_l2_response_idx), 2);
        chk("s1_psync", DATA_W'(storebuf_l2_sync_success), 0);
        chk("s1_err", DATA_W'(port_error), 0);
        tick();
        chk("s1_pulse_end", DATA_W'(storebuf_l2_response_valid), 0);

        // Backpressure with a second request pending
        l2_request_ready = 1'b0;
        sq_req(2'd0, 32'h2000, 64'hFF, pat_b, 1'b0, 1'b0);
        #1 chk("bp_ack_a", DATA_W'(sq_dequeue_ack), 1);
        tick();
        sq_req(2'd1, 32'h3000, 64'hF0, pat_a, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ack_b_blocked", DATA_W'(sq_dequeue_ack), 0);
            chk("bp_valid", DATA_W'(l2_request_valid), 1);
            chk("bp_id", DATA_W'(l2_request_id), 0);
            chk("bp_addr", DATA_W'(l2_request_addr), 32'h2000);
            chk("bp_data", l2_request_data, pat_b);
            tick();
        end
        l2_request_ready = 1'b1;
        #1 chk("bp_ack_b", DATA_W'(sq_dequeue_ack), 1);
        tick();
        sq_idle();
        chk("bp_b_valid", DATA_W'(l2_request_valid), 1);
        chk("bp_b_id", DATA_W'(l2_request_id), 1);
        chk("bp_b_addr", DATA_W'(l2_request_addr), 32'h3000);
        chk("bp_b_mask", DATA_W'(l2_request_mask), 64'hF0);
        tick();
        chk("bp_drained", DATA_W'(l2_request_valid), 0);
        rsp(2'd0, 2'd0, 1'b0);
        tick();
        chk("bp_pulse0", DATA_W'(storebuf_l2_response_idx), 0);
        chk("bp_pulse0_v", DATA_W'(storebuf_l2_response_valid), 1);
        rsp(2'd0, 2'd1, 1'b0);
        tick();
        l2_response_valid = 1'b0;
        chk("bp_pulse1", DATA_W'(storebuf_l2_response_idx), 1);
        chk("bp_pulse1_v", DATA_W'(storebuf_l2_response_valid), 1);

        // Flush beats synchronized; sync status returned
        sq_req(2'd0, 32'h4000, 64'h1, pat_b, 1'b1, 1'b1);
        #1 chk("pr_ack", DATA_W'(sq_dequeue_ack), 1);
        tick();
        sq_idle();
        chk("pr_type_flush", DATA_W'(l2_request_type), 2);
        rsp(2'd2, 2'd0, 1'b1);
        tick();
        l2_response_valid = 1'b0;
        chk("pr_flush_pulse", DATA_W'(storebuf_l2_response_valid), 1);
        chk("pr_flush_sync", DATA_W'(storebuf_l2_sync_success), 0);
        sq_req(2'd1, 32'h5000, 64'h3, pat_a, 1'b1, 1'b0);
        tick();
        sq_idle();
        chk("pr_type_sync", DATA_W'(l2_request_type), 1);
        chk("pr_sync_id", DATA_W'(l2_request_id), 1);
        rsp(2'd1, 2'd1, 1'b1);
        tick();
        l2_response_valid = 1'b0;
        chk("pr_sync_pulse", DATA_W'(storebuf_l2_response_valid), 1);
        chk("pr_sync_idx", DATA_W'(storebuf_l2_response_idx), 1);
        chk("pr_sync_ok", DATA_W'(storebuf_l2_sync_success), 1);
        chk("pr_err", DATA_W'(port_error), 0);

        // Duplicate id blocked until the completion lands
        sq_req(2'd3, 32'h6000, 64'hC, pat_b, 1'b0, 1'b0);
        #1 chk("dup_ack_first", DATA_W'(sq_dequeue_ack), 1);
        tick();
        chk("dup_ack_blk0", DATA_W'(sq_dequeue_ack), 0);
        tick();
        chk("dup_ack_blk1", DATA_W'(sq_dequeue_ack), 0);
        rsp(2'd0, 2'd3, 1'b0);
        #1 chk("dup_ack_same_cycle", DATA_W'(sq_dequeue_ack), 0);
        tick();
        l2_response_valid = 1'b0;
        chk("dup_pulse", DATA_W'(storebuf_l2_response_valid), 1);
        chk("dup_pidx", DATA_W'(storebuf_l2_response_idx), 3);
        #1 chk("dup_ack_after", DATA_W'(sq_dequeue_ack), 1);
        tick();
        sq_idle();
        chk("dup_valid", DATA_W'(l2_request_valid), 1);
        chk("dup_id", DATA_W'(l2_request_id), 3);
        rsp(2'd0, 2'd3, 1'b0);
        tick();
        l2_response_valid = 1'b0;
        chk("dup_pulse2", DATA_W'(storebuf_l2_response_valid), 1);
        chk("dup_err", DATA_W'(port_error), 0);

        // Type 3 filtered, unknown id flags a sticky error
        rsp(2'd3, 2'd0, 1'b1);
        tick();
        chk("t3_pulse", DATA_W'(storebuf_l2_response_valid), 0);
        chk("t3_err", DATA_W'(port_error), 0);
        rsp(2'd0, 2'd0, 1'b0);
        tick();
        l2_response_valid = 1'b0;
        chk("unk_pulse", DATA_W'(storebuf_l2_response_valid), 0);
        chk("unk_err", DATA_W'(port_error), 1);
        tick();
        chk("err_sticky", DATA_W'(port_error), 1);

        // Reset mid-operation: FULL with ids 0 and 1 outstanding
        sq_req(2'd0, 32'h7000, 64'hA, pat_a, 1'b0, 1'b0);
        tick();
        sq_req(2'd1, 32'h8000, 64'hB, pat_b, 1'b0, 1'b0);
        #1 chk("mr_ack1", DATA_W'(sq_dequeue_ack), 1);
        tick();
        sq_idle();
        l2_request_ready = 1'b0;
        chk("mr_full", DATA_W'(l2_request_valid), 1);
        #2 reset = 1'b0;
        #1;
        chk("mr_valid", DATA_W'(l2_request_valid), 0);
        chk("mr_id", DATA_W'(l2_request_id), 0);
        chk("mr_addr", DATA_W'(l2_request_addr), 0);
        chk("mr_data", l2_request_data, 0);
        chk("mr_err", DATA_W'(port_error), 0);
        tick();
        reset = 1'b1;
        l2_request_ready = 1'b1;
        sq_req(2'd0, 32'h9000, 64'h1, pat_a, 1'b0, 1'b0);
        #1 chk("mr_re_ack0", DATA_W'(sq_dequeue_ack), 1);
        tick();
        sq_req(2'd1, 32'hA000, 64'h2, pat_b, 1'b0, 1'b0);
        #1 chk("mr_re_ack1", DATA_W'(sq_dequeue_ack), 1);
        tick();
        sq_idle();
        chk("mr_re_id", DATA_W'(l2_request_id), 1);
        chk("mr_re_addr", DATA_W'(l2_request_addr), 32'hA000);

        // Mismatched response type still completes but flags an error
        rsp(2'd2, 2'd0, 1'b0);
        tick();
        l2_response_valid = 1'b0;
        chk("mm_pulse", DATA_W'(storebuf_l2_response_valid), 1);
        chk("mm_idx", DATA_W'(storebuf_l2_response_idx), 0);
        chk("mm_err", DATA_W'(port_error), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/l1_store_l2_port.md
# l1_store_l2_port

Sends store, synchronized-store and flush requests from the L1 store queue to the L2 interconnect, and returns matching completions to it. Sits between the store queue's dequeue port and the L2 request/response channels. It holds one registered outbound packet, applies backpressure, tracks which thread entries are outstanding, and filters store-class responses back to the queue.

## Interface
- THREADS, 4: store queue entries (one per thread); id width = $clog2(THREADS)
- LINE_BYTES, 64: cache line bytes; data width = 8*LINE_BYTES
- ADDR_WIDTH, 32: request address width
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low (0 = reset asserted)
- sq_dequeue_ready  input  1  store queue has a request
- sq_dequeue_addr  input  ADDR_WIDTH  line-aligned address
- sq_dequeue_idx  input  id  requesting entry
- sq_dequeue_mask  input  LINE_BYTES  byte enables
- sq_dequeue_data  input  8*LINE_BYTES  line data
- sq_dequeue_synchronized  input  1  synchronized store
- sq_dequeue_flush  input  1  flush request
- sq_dequeue_ack  output  1  request accepted this cycle (combinational)
- l2_request_valid  output  1  outbound packet valid
- l2_request_ready  input  1  interconnect takes the packet this cycle
- l2_request_type  output  2  0 = store, 1 = store_sync, 2 = flush
- l2_request_id, l2_request_addr, l2_request_mask, l2_request_data  output  id/ADDR_WIDTH/LINE_BYTES/8*LINE_BYTES  packet fields
- l2_response_valid  input  1  response beat
- l2_response_type  input  2  same encoding; 3 = non-store (ignored)
- l2_response_id  input  id  entry
- l2_response_status  input  1  sync success
- storebuf_l2_response_valid  output  1  completion pulse to store queue
- storebuf_l2_response_idx  output  id  completed entry
- storebuf_l2_sync_success  output  1  status for a store_sync completion, else 0
- port_error  output  1  sticky protocol error

## Operation
- Output register: states EMPTY / FULL. FULL while l2_request_valid = 1.
- sq_dequeue_ack = sq_dequeue_ready && !outstanding[sq_dequeue_idx] && (EMPTY || l2_request_ready).
- On accept: load the packet register. Type = flush if flush is set (flush wins over synchronized), else store_sync if synchronized, else store. Set outstanding[idx].
- FULL and l2_request_ready and no new accept: go to EMPTY. Accept in the same cycle as drain: stay FULL with the new packet (back-to-back, no bubble).
- Packet fields are stable while FULL and not ready.
- Response with type 0–2: if outstanding[id] = 1, clear it and emit the completion. If outstanding[id] = 0, set port_error and emit nothing. Type 3 is ignored entirely.
- Response type different from the sent type for that id (store vs store_sync vs flush, tracked per entry): set port_error but still complete.
- Response and accept for the same id in one cycle: the response clears the bit. The accept is blocked, because ack uses the pre-edge outstanding bit.
- port_error is cleared only by reset.

## Timing
- Reset values: l2_request_valid = 0, all packet fields 0, outstanding = 0, storebuf_l2_response_valid = 0, idx = 0, sync_success = 0, port_error = 0.
- Reset mid-operation discards the pending packet and all outstanding state immediately.
- Accept at edge N: l2_request_valid = 1 from cycle N+1.
- Minimum request latency is 1 cycle. Throughput is 1 packet per cycle when l2_request_ready is held at 1.
- Response sampled at edge M: storebuf_l2_response_valid is a 1-cycle pulse in cycle M+1, with idx/sync_success registered alongside.
- outstanding[id] reads 0 from cycle M+1.
- At most one response per cycle; no response buffering is required.

## Test plan
- Single store: idx 2, addr 0x1000, mask 0xF, ready held 1 → ack in cycle 0; cycle 1 shows valid, type 0, id 2, addr 0x1000; packet is gone in cycle 2. Response type 0, id 2 → completion pulse idx 2, sync_success 0.
- Backpressure: ready = 0 for 5 cycles with a second request pending → fields stay constant and second ack = 0. Ready rises → second ack in the same cycle, new packet the next cycle, no bubble.
- Priority and status: flush+synchronized → type 2. Synchronized store idx 1, then response type 1 with status 1 → sync_success 1 in the pulse cycle.
- Duplicate id: idx 3 outstanding, new request from idx 3 → ack = 0 until the cycle after the idx 3 response, then ack = 1.
- Errors and filtering: response id 0 with nothing outstanding → port_error = 1, no pulse. Type 3 response → no pulse, port_error unchanged.
- Reset mid-operation: FULL with 2 outstanding, reset driven 0 asynchronously → all outputs 0 at once. After release, idx 0 and 1 are accepted immediately.
